// File: rtl/gen_xdma_descriptor_mc_pkg.sv
// Shared definitions for the XDMA descriptor multi-channel generator:
// request field offsets, descriptor control words and FSM state encoding.
package gen_xdma_pkg;

  localparam int TDATA_W  = 104;
  localparam int LEN_LSB  = 0;
  localparam int LEN_W    = 23;
  localparam int ADDR_LSB = 32;
  localparam int ADDR_W   = 64;
  localparam int CH_LSB   = 96;
  localparam int CH_W     = 2;
  localparam int DLEN_W   = 28;

  // EOP, completed, stop
  localparam logic [15:0] DSC_CTL_LAST = 16'b10011;
  localparam logic [15:0] DSC_CTL_MID  = 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/gen_xdma_descriptor_mc_chunker.sv
// Chunk arithmetic: current chunk length, remaining bytes, next address, last flag.
// Splitting is enabled by GEN_XDMA_DSC_SPLIT_EN; otherwise every request is a single chunk.
module xdma_dsc_chunker
  import gen_xdma_pkg::*;
#(
  parameter logic [LEN_W-1:0] MAX_CHUNK = 23'h40_0000
) (
  input  logic [LEN_W-1:0]  rem,
  input  logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  chunk_len,
  output logic [LEN_W-1:0]  next_rem,
  output logic [ADDR_W-1:0] next_addr,
  output logic              last
);

`ifdef GEN_XDMA_DSC_SPLIT_EN
  assign last      = (rem <= MAX_CHUNK);
  assign chunk_len = last ? rem : MAX_CHUNK;
  assign next_rem  = rem - chunk_len;
  assign next_addr = addr + {{(ADDR_W-LEN_W){1'b0}}, MAX_CHUNK};
`else
  logic unused_max;
  assign unused_max = ^MAX_CHUNK;
  assign last      = 1'b1;
  assign chunk_len = rem;
  assign next_rem  = '0;
  assign next_addr = addr;
`endif

endmodule

// File: rtl/gen_xdma_descriptor_mc.sv
// Multi-channel XDMA C2H descriptor-bypass generator: one request in, one or more
// descriptors out on the selected channel. Define GEN_XDMA_DSC_SPLIT_EN to split at MAX_CHUNK.
//
// state | meaning
// IDLE  | accepting requests; bad requests counted and dropped here
// LOAD  | dsc_load[ch] held with stable fields until dsc_ready[ch]
module gen_xdma_descriptor_mc
  import gen_xdma_pkg::*;
#(
  parameter int               NCH       = 2,
  parameter logic [LEN_W-1:0] MAX_CHUNK = 23'h40_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [TDATA_W-1:0]   S_AXIS_tdata,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [NCH-1:0]       dsc_ready,
  output logic [NCH-1:0]       dsc_load,
  output logic [15:0]          dsc_ctl,
  output logic [63:0]          dsc_src_addr,
  output logic [63:0]          dsc_dst_addr,
  output logic [DLEN_W-1:0]    dsc_len,
  output logic [32*NCH-1:0]    counter,
  output logic [15:0]          err_count
);

  state_t            state;
  logic [CH_W-1:0]   ch_q;
  logic [LEN_W-1:0]  rem_q;
  logic [31:0]       cnt_q [NCH];

  logic [LEN_W-1:0]  req_len;
  logic [ADDR_W-1:0] req_addr;
  logic [CH_W-1:0]   req_ch;
  logic              req_bad;
  logic [NCH-1:0]    sel_oh;
  logic              sel_ready;
  logic              last_q;

  logic [LEN_W-1:0]  ck_rem;
  logic [LEN_W-1:0]  ck_len;
  logic [LEN_W-1:0]  ck_next_rem;
  logic [ADDR_W-1:0] ck_next_addr;
  logic              ck_last;

  logic unused_tdata;
  assign unused_tdata = ^{S_AXIS_tdata[ADDR_LSB-1:LEN_W], S_AXIS_tdata[TDATA_W-1:CH_LSB+CH_W]};

  assign req_len  = S_AXIS_tdata[LEN_LSB +: LEN_W];
  assign req_addr = S_AXIS_tdata[ADDR_LSB +: ADDR_W];
  assign req_ch   = S_AXIS_tdata[CH_LSB +: CH_W];
  assign req_bad  = (req_len == '0) || (int'(req_ch) >= NCH);

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NCH; i++) sel_oh[i] = (ch_q == CH_W'(i));
  end

  // Handshake outputs drop in the same cycle resetn goes low.
  assign S_AXIS_tready = resetn && (state == IDLE);
  assign dsc_load      = (resetn && (state == LOAD)) ? sel_oh : '0;
  assign sel_ready     = |(dsc_ready & sel_oh);
  assign last_q        = (dsc_ctl == DSC_CTL_LAST);
  assign dsc_src_addr  = '0;

  // First chunk is computed from the incoming request, later ones from the residue.
  assign ck_rem = (state == IDLE) ? req_len : rem_q;

  xdma_dsc_chunker #(.MAX_CHUNK(MAX_CHUNK)) u_chunker (
    .rem       (ck_rem),
    .addr      (dsc_dst_addr),
    .chunk_len (ck_len),
    .next_rem  (ck_next_rem),
    .next_addr (ck_next_addr),
    .last      (ck_last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      ch_q         <= '0;
      rem_q        <= '0;
      dsc_ctl      <= '0;
      dsc_dst_addr <= '0;
      dsc_len      <= '0;
      err_count    <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (S_AXIS_tvalid) begin
            if (req_bad) begin
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end else begin
              ch_q         <= req_ch;
              dsc_dst_addr <= req_addr;
              dsc_len      <= {{(DLEN_W-LEN_W){1'b0}}, ck_len};
              rem_q        <= ck_next_rem;
              dsc_ctl      <= ck_last ? DSC_CTL_LAST : DSC_CTL_MID;
              state        <= LOAD;
            end
          end
        end
        LOAD: begin
          if (sel_ready) begin
            if (last_q) begin
              state <= IDLE;
              for (int i = 0; i < NCH; i++)
                if (sel_oh[i]) cnt_q[i] <= cnt_q[i] + 32'd1;
            end else begin
              dsc_dst_addr <= ck_next_addr;
              dsc_len      <= {{(DLEN_W-LEN_W){1'b0}}, ck_len};
              rem_q        <= ck_next_rem;
              dsc_ctl      <= ck_last ? DSC_CTL_LAST : DSC_CTL_MID;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_cnt
    assign counter[32*k +: 32] = cnt_q[k];
  end

endmodule

// File: tb/tb_gen_xdma_descriptor_mc.sv
// Directed bench for gen_xdma_descriptor_mc: vector table of single-descriptor
// requests plus hand-written stall, split, reset and back-to-back sequences.
module tb_gen_xdma_descriptor_mc;

  localparam int NCH = 2;
  localparam logic [15:0] CTL_LAST = 16'h0013;

  logic              clk = 1'b0;
  logic              resetn;
  logic [103:0]      S_AXIS_tdata;
  logic              S_AXIS_tvalid;
  logic              S_AXIS_tready;
  logic [NCH-1:0]    dsc_ready;
  logic [NCH-1:0]    dsc_load;
  logic [15:0]       dsc_ctl;
  logic [63:0]       dsc_src_addr;
  logic [63:0]       dsc_dst_addr;
  logic [27:0]       dsc_len;
  logic [32*NCH-1:0] counter;
  logic [15:0]       err_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt [NCH];

  typedef struct {
    logic [1:0]  ch;
    logic [22:0] len;
    logic [63:0] addr;
    logic [27:0] exp_len;
    logic [15:0] exp_ctl;
  } vec_t;

  vec_t vecs [5];

  gen_xdma_descriptor_mc #(.NCH(NCH), .MAX_CHUNK(23'h40_0000)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .dsc_ready     (dsc_ready),
    .dsc_load      (dsc_load),
    .dsc_ctl       (dsc_ctl),
    .dsc_src_addr  (dsc_src_addr),
    .dsc_dst_addr  (dsc_dst_addr),
    .dsc_len       (dsc_len),
    .counter       (counter),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [103:0] mk(input logic [1:0] ch, input logic [22:0] len,
                                      input logic [63:0] addr);
    logic [103:0] d;
    d = '0;
    d[22:0]  = len;
    d[95:32] = addr;
    d[97:96] = ch;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    for (int k = 0; k < NCH; k++)
      chk($sformatf("%s_cnt%0d", tag, k), 64'(counter[32*k +: 32]), 64'(exp_cnt[k]));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [NCH-1:0] oh;
    oh = '0;
    oh[v.ch] = 1'b1;
    S_AXIS_tdata  = mk(v.ch, v.len, v.addr);
    S_AXIS_tvalid = 1'b1;
    dsc_ready     = '1;
    chk($sformatf("v%0d_tready_idle", idx), 64'(S_AXIS_tready), 64'd1);
    step();
    S_AXIS_tvalid = 1'b0;
    chk($sformatf("v%0d_load", idx), 64'(dsc_load), 64'(oh));
    chk($sformatf("v%0d_len", idx), 64'(dsc_len), 64'(v.exp_len));
    chk($sformatf("v%0d_ctl", idx), 64'(dsc_ctl), 64'(v.exp_ctl));
    chk($sformatf("v%0d_dst", idx), dsc_dst_addr, v.addr);
    chk($sformatf("v%0d_src", idx), dsc_src_addr, 64'd0);
    chk($sformatf("v%0d_tready_load", idx), 64'(S_AXIS_tready), 64'd0);
    step();
    chk($sformatf("v%0d_load_done", idx), 64'(dsc_load), 64'd0);
    chk($sformatf("v%0d_tready_done", idx), 64'(S_AXIS_tready), 64'd1);
    exp_cnt[v.ch] = exp_cnt[v.ch] + 32'd1;
  endtask

  initial begin
    int sent;
    int cycles;
    logic acc;

    vecs[0] = '{ch: 2'd0, len: 23'h1000,   addr: 64'h1_0000_0000,        exp_len: 28'h1000,   exp_ctl: CTL_LAST};
    vecs[1] = '{ch: 2'd1, len: 23'h40,     addr: 64'hFFFF_FFFF_FFFF_FFC0, exp_len: 28'h40,     exp_ctl: CTL_LAST};
    vecs[2] = '{ch: 2'd1, len: 23'h1,      addr: 64'h10,                 exp_len: 28'h1,      exp_ctl: CTL_LAST};
    vecs[3] = '{ch: 2'd0, len: 23'h400000, addr: 64'h80,                 exp_len: 28'h400000, exp_ctl: CTL_LAST};
    vecs[4] = '{ch: 2'd0, len: 23'h3FFFC0, addr: 64'hDEAD_0000,          exp_len: 28'h3FFFC0, exp_ctl: CTL_LAST};

    for (int k = 0; k < NCH; k++) exp_cnt[k] = '0;
    resetn        = 1'b0;
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tdata  = '0;
    dsc_ready     = '0;
    repeat (3) step();

    chk("rst_tready", 64'(S_AXIS_tready), 64'd0);
    chk("rst_load", 64'(dsc_load), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_ctl", 64'(dsc_ctl), 64'd0);
    chk("rst_len", 64'(dsc_len), 64'd0);
    chk("rst_dst", dsc_dst_addr, 64'd0);
    chk_counters("rst");

    resetn = 1'b1;
    step();
    chk("idle_tready", 64'(S_AXIS_tready), 64'd1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
    chk_counters("table");

    // Bad requests: zero length, then out-of-range channel.
    S_AXIS_tdata  = mk(2'd0, 23'h0, 64'h100);
    S_AXIS_tvalid = 1'b1;
    step();
    S_AXIS_tvalid = 1'b0;
    chk("bad0_load", 64'(dsc_load), 64'd0);
    chk("bad0_tready", 64'(S_AXIS_tready), 64'd1);
    chk("bad0_err", 64'(err_count), 64'd1);
    S_AXIS_tdata  = mk(2'd3, 23'h100, 64'h0);
    S_AXIS_tvalid = 1'b1;
    step();
    S_AXIS_tvalid = 1'b0;
    chk("bad1_load", 64'(dsc_load), 64'd0);
    step();
    chk("bad1_load_after", 64'(dsc_load), 64'd0);
    chk("bad1_err", 64'(err_count), 64'd2);
    chk_counters("bad");

    // Stall: selected channel not ready, other channel ready.
    S_AXIS_tdata  = mk(2'd0, 23'h200, 64'hABC0);
    S_AXIS_tvalid = 1'b1;
    dsc_ready     = 2'b10;
    step();
    S_AXIS_tvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall%0d_load", i), 64'(dsc_load), 64'd1);
      chk($sformatf("stall%0d_dst", i), dsc_dst_addr, 64'hABC0);
      chk($sformatf("stall%0d_len", i), 64'(dsc_len), 64'h200);
      chk($sformatf("stall%0d_ctl", i), 64'(dsc_ctl), 64'(CTL_LAST));
      chk($sformatf("stall%0d_tready", i), 64'(S_AXIS_tready), 64'd0);
      step();
    end
    dsc_ready = 2'b01;
    step();
    chk("stall_done_load", 64'(dsc_load), 64'd0);
    chk("stall_done_tready", 64'(S_AXIS_tready), 64'd1);
    exp_cnt[0] = exp_cnt[0] + 32'd1;
    chk_counters("stall");

    // Long request on ch1.
    S_AXIS_tdata  = mk(2'd1, 23'h500000, 64'h2000);
    S_AXIS_tvalid = 1'b1;
    dsc_ready     = 2'b00;
    step();
    S_AXIS_tvalid = 1'b0;
    chk("split_c0_load", 64'(dsc_load), 64'd2);
    chk("split_c0_dst", dsc_dst_addr, 64'h2000);
`ifdef GEN_XDMA_DSC_SPLIT_EN
    chk("split_c0_len", 64'(dsc_len), 64'h400000);
    chk("split_c0_ctl", 64'(dsc_ctl), 64'h0);
    dsc_ready = 2'b10;
    step();
    chk("split_c1_load", 64'(dsc_load), 64'd2);
    chk("split_c1_dst", dsc_dst_addr, 64'h402000);
    chk("split_c1_len", 64'(dsc_len), 64'h100000);
    chk("split_c1_ctl", 64'(dsc_ctl), 64'(CTL_LAST));
    chk("split_c1_tready", 64'(S_AXIS_tready), 64'd0);
    chk_counters("split_mid");
`else
    chk("split_c0_len", 64'(dsc_len), 64'h500000);
    chk("split_c0_ctl", 64'(dsc_ctl), 64'(CTL_LAST));
    dsc_ready = 2'b10;
`endif
    step();
    chk("split_done_load", 64'(dsc_load), 64'd0);
    chk("split_done_tready", 64'(S_AXIS_tready), 64'd1);
    exp_cnt[1] = exp_cnt[1] + 32'd1;
    chk_counters("split");

    // Reset in the middle of a LOAD.
    S_AXIS_tdata  = mk(2'd0, 23'h500000, 64'h0);
    S_AXIS_tvalid = 1'b1;
    dsc_ready     = 2'b00;
    step();
    S_AXIS_tvalid = 1'b0;
    chk("rstmid_load_before", 64'(dsc_load), 64'd1);
    resetn = 1'b0;
    #1;
    chk("rstmid_load_comb", 64'(dsc_load), 64'd0);
    chk("rstmid_tready_comb", 64'(S_AXIS_tready), 64'd0);
    step();
    for (int k = 0; k < NCH; k++) exp_cnt[k] = '0;
    chk_counters("rstmid");
    chk("rstmid_err", 64'(err_count), 64'd0);
    chk("rstmid_len", 64'(dsc_len), 64'd0);
    chk("rstmid_ctl", 64'(dsc_ctl), 64'd0);
    resetn = 1'b1;
    step();
    chk("rstmid_idle_tready", 64'(S_AXIS_tready), 64'd1);
    chk("rstmid_idle_load", 64'(dsc_load), 64'd0);
    run_vec('{ch: 2'd1, len: 23'h80, addr: 64'h1000, exp_len: 28'h80, exp_ctl: CTL_LAST}, 9);
    chk_counters("post_rst");

    // 100 back-to-back requests alternating channels.
    dsc_ready     = 2'b11;
    sent          = 0;
    cycles        = 0;
    S_AXIS_tdata  = mk(2'd0, 23'h40, 64'h0);
    S_AXIS_tvalid = 1'b1;
    while (cycles < 1000) begin
      acc = S_AXIS_tvalid && S_AXIS_tready;
      step();
      cycles++;
      if (acc) begin
        exp_cnt[(sent % 2)] = exp_cnt[(sent % 2)] + 32'd1;
        sent++;
        if (sent == 100) S_AXIS_tvalid = 1'b0;
        else S_AXIS_tdata = mk(2'(sent % 2), 23'h40, 64'(sent * 64));
      end
      if (sent == 100 && S_AXIS_tready && dsc_load == '0) break;
    end
    chk("b2b_cycles", 64'(cycles), 64'd200);
    chk("b2b_sent", 64'(sent), 64'd100);
    chk_counters("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gen_xdma_descriptor_mc.md
GEN_XDMA_DESCRIPTOR_MC -- requirements
Module: gen_xdma_descriptor_mc

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of XDMA C2H descriptor channels (1..4).
REQ-002 SHALL have parameter MAX_CHUNK, default 23'h40_0000, meaning maximum bytes per emitted descriptor (nonzero, multiple of 64).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is synchronous to it.
REQ-004 SHALL have port resetn, input, 1, meaning synchronous active-low reset.
REQ-005 SHALL have port S_AXIS_tdata, input, 104, meaning request: [22:0] length bytes, [95:32] destination address, [97:96] channel index.
REQ-006 SHALL have ports S_AXIS_tvalid (input, 1) and S_AXIS_tready (output, 1), meaning the request AXI-Stream handshake; no tlast or tkeep.
REQ-007 SHALL have port dsc_ready, input, NCH, meaning per-channel XDMA descriptor-bypass ready.
REQ-008 SHALL have port dsc_load, output, NCH, meaning per-channel descriptor load strobe.
REQ-009 SHALL have ports dsc_ctl (16), dsc_src_addr (64), dsc_dst_addr (64) and dsc_len (28), all outputs shared by all channels, meaning descriptor fields; dsc_src_addr is constant 0.
REQ-010 SHALL have port counter, output, 32*NCH, meaning per-channel completed-request count; channel k occupies [32k+31:32k].
REQ-011 SHALL have port err_count, output, 16, meaning the count of discarded requests.

Function
REQ-012 SHALL implement FSM states IDLE and LOAD.
REQ-013 In IDLE, S_AXIS_tready SHALL be 1 while resetn=1; dsc_load SHALL be all-zero.
REQ-014 On tvalid&tready in IDLE with length>0 and channel<NCH, the FSM SHALL latch channel, address and length and enter LOAD on the next cycle.
REQ-015 A request with length=0 or channel>=NCH SHALL be consumed without emitting a descriptor, SHALL increment err_count (saturating at 16'hFFFF) and SHALL leave the FSM in IDLE.
REQ-016 In LOAD, S_AXIS_tready SHALL be 0 and dsc_load[ch] SHALL be 1; all other dsc_load bits SHALL be 0; the fields SHALL stay stable until dsc_ready[ch]=1.
REQ-017 dsc_ready bits of non-selected channels SHALL be ignored.
REQ-018 A non-final chunk SHALL have dsc_ctl=16'h0000; the final chunk SHALL have dsc_ctl=16'b10011 (EOP, completed, stop).
REQ-019 When dsc_ready[ch]=1 in LOAD on the final chunk, the FSM SHALL return to IDLE and counter[ch] SHALL increment by 1, wrapping at 2^32.
REQ-020 When dsc_ready[ch]=1 in LOAD on a non-final chunk, the FSM SHALL stay in LOAD for the next chunk.
REQ-021 The next chunk SHALL have dsc_dst_addr advanced by MAX_CHUNK (64-bit add, wrap permitted) and its fields SHALL be valid on the following cycle.
REQ-022 Chunk length SHALL be min(remaining, MAX_CHUNK), zero-extended to 28 bits.
REQ-023 Request-to-dsc_load latency SHALL be 1 cycle; back-to-back requests SHALL sustain one request per 2 cycles when dsc_ready is held at 1.

Reset
REQ-024 While resetn=0, S_AXIS_tready and dsc_load SHALL be 0 combinationally, in the same cycle.
REQ-025 On reset, the FSM SHALL go to IDLE and counter, err_count, dsc_ctl, dsc_dst_addr and dsc_len SHALL become 0.
REQ-026 Reset asserted during LOAD SHALL abandon the remaining chunks without incrementing the counter.

Configuration
REQ-027 With GEN_XDMA_DSC_SPLIT_EN defined, the block SHALL split requests longer than MAX_CHUNK as specified in REQ-018 to REQ-022.
REQ-028 Without GEN_XDMA_DSC_SPLIT_EN, the block SHALL emit exactly one descriptor per request with dsc_len equal to the full 23-bit length and dsc_ctl=16'b10011; MAX_CHUNK SHALL be unused.

Structure
REQ-029 Package gen_xdma_pkg SHALL hold the tdata field offsets, the channel-field width, DSC_CTL_LAST=16'b10011, DSC_CTL_MID=16'h0000 and the FSM state enum.
REQ-030 Chunk arithmetic (remaining, next address, last flag) SHALL be the sub-module xdma_dsc_chunker; the FSM, counters and muxing SHALL be in the top module.

Verification
REQ-031 The bench SHALL cover: ch0, len 0x1000, addr 0x1_0000_0000, dsc_ready=1 -> one dsc_load[0] pulse, dsc_len=0x1000, dsc_ctl=0x13, counter[0]=1.
REQ-032 The bench SHALL cover, with SPLIT_EN and MAX_CHUNK=0x400000: ch1, len 0x500000, addr 0x2000 -> descriptor (0x2000, 0x400000, ctl 0) then (0x402000, 0x100000, ctl 0x13), and counter[1]=1.
REQ-033 The bench SHALL cover: len 0 on ch0, then channel index 3 with NCH=2 -> no dsc_load, err_count=2, counters unchanged.
REQ-034 The bench SHALL cover: dsc_ready[ch] held low 10 cycles while the other channel's dsc_ready=1 -> dsc_load held with stable fields, tready=0, and no other channel load.
REQ-035 The bench SHALL cover: resetn=0 mid-LOAD of the first split chunk -> dsc_load=0 in the same cycle, the FSM in IDLE, all counters 0, and the next request handled normally.
REQ-036 The bench SHALL cover: 100 back-to-back requests alternating ch0/ch1 with dsc_ready=1 -> 200 cycles total and counter[0]=counter[1]=50.
